// File: rtl/regfile_onehot_wr_if.sv
// Bus bundle for the one-hot-write register file: write strobe/data, two read
// ports, the sticky select-error flag and the committed-write counter.
interface regfile_onehot_wr_if #(
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [7:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        rd_addr1;
    logic [2:0]        rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              err_clr;
    logic              sel_err;
    logic [15:0]       wr_count;

    modport master (
        output wr_en, wr_sel, wr_data, rd_addr1, rd_addr2, err_clr,
        input  rd_data1, rd_data2, sel_err, wr_count
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_addr1, rd_addr2, err_clr,
        output rd_data1, rd_data2, sel_err, wr_count
    );
endinterface

// File: rtl/regfile_onehot_wr.sv
// 8 x DATA_W register file written through a one-hot select vector, with two
// combinational read ports, optional write bypass and a sticky illegal-select flag.
module regfile_onehot_wr #(
    parameter int DATA_W  = 16,
    parameter bit R0_ZERO = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    regfile_onehot_wr_if.slave  bus
);

    function automatic logic f_is_onehot(input logic [7:0] sel);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt = cnt + {3'd0, sel[k]};
        end
        return (cnt == 4'd1);
    endfunction

    logic [DATA_W-1:0] r_regs [0:7];
    logic              r_sel_err;
    logic [15:0]       r_wr_count;

    logic              w_sel_known;
    logic              w_legal;
    logic              w_commit;
    logic              w_illegal;
    logic              w_count_inc;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;

    // Unknown select bits fold to "not legal" so they can never strobe a register.
    assign w_sel_known = ((^bus.wr_sel) !== 1'bx);
    assign w_legal     = w_sel_known && f_is_onehot(bus.wr_sel);
    assign w_commit    = bus.wr_en && w_legal;
    assign w_illegal   = bus.wr_en && !w_legal;
    assign w_count_inc = w_commit && !(R0_ZERO && bus.wr_sel[0]);

    // Register array, error flag and write counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 8; k++) begin
                r_regs[k] <= '0;
            end
            r_sel_err  <= 1'b0;
            r_wr_count <= 16'd0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_commit && bus.wr_sel[k] && !(R0_ZERO && (k == 0))) begin
                    r_regs[k] <= bus.wr_data;
                end
            end
            if (w_count_inc) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_illegal) begin
                r_sel_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_sel_err <= 1'b0;
            end
        end
    end

    // Read ports: hard-zero R0 first, then same-cycle bypass, else stored value.
    always_comb begin
        w_rd_data1 = r_regs[bus.rd_addr1];
        if (R0_ZERO && (bus.rd_addr1 == 3'd0)) begin
            w_rd_data1 = '0;
        end else if (BYPASS && w_commit && bus.wr_sel[bus.rd_addr1]) begin
            w_rd_data1 = bus.wr_data;
        end else begin
            w_rd_data1 = r_regs[bus.rd_addr1];
        end

        w_rd_data2 = r_regs[bus.rd_addr2];
        if (R0_ZERO && (bus.rd_addr2 == 3'd0)) begin
            w_rd_data2 = '0;
        end else if (BYPASS && w_commit && bus.wr_sel[bus.rd_addr2]) begin
            w_rd_data2 = bus.wr_data;
        end else begin
            w_rd_data2 = r_regs[bus.rd_addr2];
        end
    end

    assign bus.rd_data1 = w_rd_data1;
    assign bus.rd_data2 = w_rd_data2;
    assign bus.sel_err  = r_sel_err;
    assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr: directed vector table, random
// traffic against an array-based reference model, reset and counter-wrap cases.
module tb_regfile_onehot_wr;

    logic clk;
    logic rst;

    regfile_onehot_wr_if #(.DATA_W(16)) bus ();

    regfile_onehot_wr #(
        .DATA_W  (16),
        .R0_ZERO (1'b1),
        .BYPASS  (1'b1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [15:0] m_regs [8];
    logic        m_err;
    logic [15:0] m_cnt;

    typedef struct {
        logic        en;
        logic [7:0]  sel;
        logic [15:0] data;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic        clr;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        eerr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a, input logic en,
                                               input logic [7:0] sel, input logic [15:0] data);
        if (a == 3'd0) return 16'h0000;
        if (en && ($countones(sel) == 1) && sel[a]) return data;
        return m_regs[a];
    endfunction

    task automatic model_edge(input logic r, input logic en, input logic [7:0] sel,
                              input logic [15:0] data, input logic clr);
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_err = 1'b0;
            m_cnt = 16'h0000;
        end else if (en && ($countones(sel) == 1)) begin
            for (int i = 1; i < 8; i++) begin
                if (sel == (8'h01 << i)) begin
                    m_regs[i] = data;
                    m_cnt     = m_cnt + 16'd1;
                end
            end
            if (clr) m_err = 1'b0;
        end else if (en) begin
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [7:0] sel,
                         input logic [15:0] data, input logic [2:0] a1,
                         input logic [2:0] a2, input logic clr);
        @(negedge clk);
        rst          = r;
        bus.wr_en    = en;
        bus.wr_sel   = sel;
        bus.wr_data  = data;
        bus.rd_addr1 = a1;
        bus.rd_addr2 = a2;
        bus.err_clr  = clr;
    endtask

    // One model-checked cycle: reads before the edge, state after it.
    task automatic mstep(input string tag, input logic r, input logic en, input logic [7:0] sel,
                         input logic [15:0] data, input logic [2:0] a1,
                         input logic [2:0] a2, input logic clr);
        drive(r, en, sel, data, a1, a2, clr);
        #1;
        check({tag, " rd_data1"}, {16'h0, bus.rd_data1}, {16'h0, model_read(a1, en, sel, data)});
        check({tag, " rd_data2"}, {16'h0, bus.rd_data2}, {16'h0, model_read(a2, en, sel, data)});
        @(posedge clk);
        model_edge(r, en, sel, data, clr);
        #1;
        check({tag, " sel_err"},  {31'h0, bus.sel_err},  {31'h0, m_err});
        check({tag, " wr_count"}, {16'h0, bus.wr_count}, {16'h0, m_cnt});
    endtask

    initial begin
        vec_t v;
        logic [7:0] rsel;

        vecs[0]  = '{1'b1, 8'h08, 16'hBEEF, 3'd3, 3'd3, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 16'd1};
        vecs[1]  = '{1'b0, 8'h00, 16'h0000, 3'd3, 3'd0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 16'd1};
        vecs[2]  = '{1'b1, 8'h01, 16'h1234, 3'd0, 3'd3, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 8'h00, 16'h0000, 3'd0, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 8'h0C, 16'hFFFF, 3'd2, 3'd3, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 16'd1};
        vecs[5]  = '{1'b0, 8'h00, 16'h0000, 3'd2, 3'd3, 1'b1, 16'h0000, 16'hBEEF, 1'b0, 16'd1};
        vecs[6]  = '{1'b1, 8'h00, 16'h5555, 3'd2, 3'd3, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 16'd1};
        vecs[7]  = '{1'b0, 8'h00, 16'h0000, 3'd3, 3'd3, 1'b0, 16'hBEEF, 16'hBEEF, 1'b1, 16'd1};
        vecs[8]  = '{1'b1, 8'h30, 16'h4321, 3'd4, 3'd5, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'd1};
        vecs[9]  = '{1'b0, 8'hFF, 16'hAAAA, 3'd7, 3'd1, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 8'hFF, 16'hAAAA, 3'd7, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 8'h80, 16'h7777, 3'd7, 3'd6, 1'b0, 16'h7777, 16'h0000, 1'b0, 16'd2};
        vecs[12] = '{1'b0, 8'h00, 16'h0000, 3'd7, 3'd3, 1'b0, 16'h7777, 16'hBEEF, 1'b0, 16'd2};

        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 8'h00;
        bus.wr_data  = 16'h0000;
        bus.rd_addr1 = 3'd0;
        bus.rd_addr2 = 3'd0;
        bus.err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        model_edge(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);

        // Post-reset: every register reads zero on both ports.
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 1'b0, 8'h00, 16'h0000, 3'(a), 3'(7 - a), 1'b0);
            #1;
            check("reset rd_data1", {16'h0, bus.rd_data1}, 32'h0);
            check("reset rd_data2", {16'h0, bus.rd_data2}, 32'h0);
        end
        check("reset sel_err",  {31'h0, bus.sel_err},  32'h0);
        check("reset wr_count", {16'h0, bus.wr_count}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            drive(1'b0, v.en, v.sel, v.data, v.a1, v.a2, v.clr);
            #1;
            check("vec rd_data1", {16'h0, bus.rd_data1}, {16'h0, v.e1});
            check("vec rd_data2", {16'h0, bus.rd_data2}, {16'h0, v.e2});
            @(posedge clk);
            model_edge(1'b0, v.en, v.sel, v.data, v.clr);
            #1;
            check("vec sel_err",  {31'h0, bus.sel_err},  {31'h0, v.eerr});
            check("vec wr_count", {16'h0, bus.wr_count}, {16'h0, v.ecnt});
        end

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       rsel = 8'h00;
                1:       rsel = 8'($urandom_range(0, 255));
                2:       rsel = 8'h01;
                default: rsel = 8'h01 << $urandom_range(0, 7);
            endcase
            mstep("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rsel,
                  16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end

        // Fill R1..R7, then reset together with a legal write to R5.
        for (int i = 1; i < 8; i++) begin
            mstep("fill", 1'b0, 1'b1, 8'h01 << i, 16'(16'h1111 * i), 3'(i), 3'(i - 1), 1'b0);
        end
        mstep("rst+wr", 1'b1, 1'b1, 8'h20, 16'hABCD, 3'd5, 3'd4, 1'b0);
        for (int a = 0; a < 8; a++) begin
            mstep("after rst", 1'b0, 1'b0, 8'h00, 16'h0000, 3'(a), 3'(7 - a), 1'b0);
        end
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 3'd5, 3'd5, 1'b0);
        #1;
        check("R5 dropped", {16'h0, bus.rd_data1}, 32'h0);
        check("rst wr_count", {16'h0, bus.wr_count}, 32'h0);

        // Counter wrap: 65535 legal writes, then one more.
        for (int n = 0; n < 65535; n++) begin
            drive(1'b0, 1'b1, 8'h02, 16'(n), 3'd1, 3'd2, 1'b0);
            @(posedge clk);
            model_edge(1'b0, 1'b1, 8'h02, 16'(n), 1'b0);
        end
        #1;
        check("count at FFFF", {16'h0, bus.wr_count}, 32'h0000_FFFF);
        mstep("wrap", 1'b0, 1'b1, 8'h40, 16'hC0DE, 3'd6, 3'd1, 1'b0);
        check("count wrapped", {16'h0, bus.wr_count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
